// File: rtl/clap_pkg.sv
// Shared definitions for the clap chain: detector state encoding and default
// timing constants at 100 MHz. The controller's gap timeout reuses the constants.
package clap_pkg;

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_HIGH     = 2'b01;
  localparam logic [1:0] ST_LOCKOUT  = 2'b10;
  localparam logic [1:0] ST_WAIT_LOW = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    HIGH     = ST_HIGH,
    LOCKOUT  = ST_LOCKOUT,
    WAIT_LOW = ST_WAIT_LOW
  } det_state_e;

  localparam int unsigned MIN_HIGH_CYCLES_DEF = 100_000;
  localparam int unsigned MAX_HIGH_CYCLES_DEF = 5_000_000;
  localparam int unsigned LOCKOUT_CYCLES_DEF  = 10_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on
// synchronous active-low reset.
module signal_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clap_detector.sv
// Qualifies the synchronised comparator output into single-cycle clap events:
// accepts high pulses of MIN..MAX cycles, then holds off for a lockout window.
module clap_detector
  import clap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned MIN_HIGH_CYCLES = MIN_HIGH_CYCLES_DEF,
  parameter int unsigned MAX_HIGH_CYCLES = MAX_HIGH_CYCLES_DEF,
  parameter int unsigned LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF,
  parameter int unsigned CNT_W           = $clog2(max_u(MAX_HIGH_CYCLES, LOCKOUT_CYCLES) + 1)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic mic_i,
  output logic clap_o,
  output logic busy_o
);

  if (MIN_HIGH_CYCLES < 1 || MIN_HIGH_CYCLES > MAX_HIGH_CYCLES ||
      LOCKOUT_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_err
    $error("clap_detector: illegal timing or synchroniser parameters");
  end

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic             mic_s;
  det_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clap_q;
  logic             busy_q;

  signal_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_mic_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (mic_i),
    .q_o     (mic_s)
  );

  // One counter serves both pulse measurement (HIGH) and dead time (LOCKOUT).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      clap_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mic_s) begin
            state_q <= HIGH;
            cnt_q   <= CNT_ONE;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (mic_s) begin
            if (cnt_q == MAX_C) begin
              state_q <= WAIT_LOW;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else if (cnt_q >= MIN_C) begin
            state_q <= LOCKOUT;
            cnt_q   <= '0;
            clap_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (cnt_q == LOCK_LAST) begin
            state_q <= WAIT_LOW;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // A pulse still high after lockout must fall before anything is measured.
        WAIT_LOW: begin
          if (!mic_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clap_o = clap_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_clap_detector.sv
// Bench for clap_detector: pulse-level stimulus with a run-length reference
// model feeding an expected-clap queue consumed by a per-cycle monitor.
module tb_clap_detector;

  localparam int SYNC = 2;
  localparam int MINC = 4;
  localparam int MAXC = 20;
  localparam int LOCK = 30;
  localparam int MAXN = 8192;

  logic clk = 1'b0;
  logic rst_n;
  logic mic;
  logic clap;
  logic busy;

  always #5 clk = ~clk;

  clap_detector #(
    .SYNC_STAGES     (SYNC),
    .MIN_HIGH_CYCLES (MINC),
    .MAX_HIGH_CYCLES (MAXC),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .mic_i   (mic),
    .clap_o  (clap),
    .busy_o  (busy)
  );

  bit mic_a  [MAXN];
  bit rst_a  [MAXN];
  bit s_a    [MAXN];
  bit busy_e [MAXN];
  int n = 0;
  int exp_q[$];

  int checks = 0;
  int failures = 0;
  int edge_cnt = -1;
  bit ready = 1'b0;
  bit mon_done = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic add(input bit m, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        mic_a[n] = m;
        rst_a[n] = 1'b0;
        n++;
      end
    end
  endtask

  task automatic add_rst(input bit m, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        mic_a[n] = m;
        rst_a[n] = 1'b1;
        n++;
      end
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    add(1'b1, hi);
    add(1'b0, lo);
  endtask

  task automatic mark_busy(input int from, input int upto);
    for (int k = from; k <= upto; k++) busy_e[k] = 1'b1;
  endtask

  // Reference: find runs of 1 in the synchronised stream, classify each run by
  // length, and work out when the detector is next free to measure.
  task automatic build_model();
    int j, t, e, w, len;
    bit flushed;
    for (int k = 0; k < n; k++) begin
      flushed = (k < SYNC);
      for (int d = 1; d <= SYNC; d++) if (k - d >= 0 && rst_a[k-d]) flushed = 1'b1;
      s_a[k] = flushed ? 1'b0 : mic_a[k-SYNC];
      busy_e[k] = 1'b0;
    end
    j = 0;
    while (j < n) begin
      if (rst_a[j] || !s_a[j]) begin
        j++;
        continue;
      end
      t = j;
      e = t;
      while (e < n && !rst_a[e] && s_a[e]) e++;
      len = e - t;
      if (e >= n) begin
        mark_busy(t, n - 1);
        j = n;
      end else if (rst_a[e]) begin
        mark_busy(t, e - 1);
        j = e;
      end else if (len < MINC || len > MAXC) begin
        mark_busy(t, e - 1);
        j = e + 1;
      end else begin
        exp_q.push_back(e);
        w = e + 1;
        while (w < n && !rst_a[w] && (w <= e + LOCK || s_a[w])) w++;
        mark_busy(t, w - 1);
        if (w >= n) j = n;
        else if (rst_a[w]) j = w;
        else j = w + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    bit exp_c;
    if (ready && edge_cnt >= 0 && edge_cnt < n) begin
      checks++;
      if (busy !== busy_e[edge_cnt]) begin
        failures++;
        $display("FAIL busy edge=%0d got=%b exp=%b", edge_cnt, busy, busy_e[edge_cnt]);
      end
      exp_c = (exp_q.size() > 0 && exp_q[0] == edge_cnt);
      if (exp_c) void'(exp_q.pop_front());
      checks++;
      if (clap !== exp_c) begin
        failures++;
        $display("FAIL clap edge=%0d got=%b exp=%b", edge_cnt, clap, exp_c);
      end
    end else if (ready && !mon_done && edge_cnt >= n + 2) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL pending_claps got=%0d exp=0", exp_q.size());
      end
      mon_done = 1'b1;
    end
  end

  initial begin
    int hi, lo;
    mic = 1'b0;
    rst_n = 1'b0;

    add_rst(1'b0, 3);
    add(1'b0, 5);
    pulse(3, 40);                                  // glitch
    pulse(10, 60);                                 // nominal clap
    pulse(4, 60);                                  // shortest accepted
    pulse(20, 60);                                 // longest accepted
    pulse(21, 30);                                 // one too long
    pulse(25, 30);
    pulse(10, 10); pulse(10, 60);                  // second inside lockout
    pulse(10, 50); pulse(10, 60);                  // second after lockout
    pulse(10, 25); pulse(40, 60);                  // held across lockout end
    add(1'b1, 7); add_rst(1'b1, 1); add(1'b1, 2);  // reset mid-pulse
    add(1'b0, 40);
    pulse(10, 60);

    for (int p = 0; p < 45; p++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0: hi = 3;
          1: hi = 4;
          2: hi = 5;
          3: hi = 19;
          4: hi = 20;
          default: hi = 21;
        endcase
      end else begin
        hi = $urandom_range(1, 30);
      end
      lo = $urandom_range(1, 50);
      if ($urandom_range(0, 11) == 0) begin
        add(1'b1, (hi + 1) / 2);
        add_rst(1'b1, 1);
        add(1'b1, hi / 2);
        add(1'b0, lo);
      end else begin
        pulse(hi, lo);
      end
    end
    add(1'b0, 80);

    build_model();
    ready = 1'b1;

    for (int k = 0; k < n; k++) begin
      mic = mic_a[k];
      rst_n = !rst_a[k];
      @(posedge clk);
      #1;
    end
    mic = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 20 && !mon_done; i++) @(posedge clk);
    if (!mon_done) begin
      $display("FAIL monitor_timeout got=not_done exp=done");
      $fatal(1, "monitor did not complete");
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
